// File: rtl/lfu_pkg.sv
// Shared definitions for the button request generator and the LFU it feeds.
package lfu_pkg;

    localparam int unsigned NUM_BTN        = 5;
    localparam int unsigned DEB_TICKS_DEF  = 3;
    localparam int unsigned FIFO_DEPTH_DEF = 4;

    typedef logic [2:0] btn_id_t;

    // Button index 0..NUM_BTN-1 maps to line id 1..NUM_BTN; id 0 means "none".
    function automatic btn_id_t btn_id(input int idx);
        return btn_id_t'(idx + 1);
    endfunction

endpackage

// File: rtl/btn_req_gen_if.sv
// Request handshake between the button request generator and the LFU.
interface btn_req_gen_if;
    import lfu_pkg::*;

    logic    req_valid;
    btn_id_t req_id;
    logic    req_ready;

    modport master (output req_valid, output req_id, input  req_ready);
    modport slave  (input  req_valid, input  req_id, output req_ready);

endinterface

// File: rtl/btn_debounce.sv
// Per-button 2-flop synchronizer, tick-sampled debouncer and rising-edge press pulse.
module btn_debounce
    import lfu_pkg::*;
#(
    parameter int unsigned DEB_TICKS = DEB_TICKS_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic btn,
    output logic press
);

    localparam int unsigned CW = $clog2(DEB_TICKS + 1);

    logic [1:0]    sync_q;
    logic          stable_q;
    logic [CW-1:0] cnt_q;

    // The stable level flips on the DEB_TICKS-th consecutive differing tick sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q   <= '0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            press    <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn};
            press  <= 1'b0;
            if (tick) begin
                if (sync_q[1] != stable_q) begin
                    if (cnt_q == CW'(DEB_TICKS - 1)) begin
                        stable_q <= sync_q[1];
                        cnt_q    <= '0;
                        press    <= sync_q[1];
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end else begin
                    cnt_q <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/btn_req_gen.sv
// Debounced push-buttons -> pending mask -> priority arbiter -> request FIFO -> LFU handshake.
module btn_req_gen
    import lfu_pkg::*;
#(
    parameter int unsigned DEB_TICKS  = DEB_TICKS_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick,
    input  logic          b1,
    input  logic          b2,
    input  logic          b3,
    input  logic          b4,
    input  logic          b5,
    btn_req_gen_if.master req,
    output logic          overflow
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [NUM_BTN-1:0] btns;
    logic [NUM_BTN-1:0] press;

    assign btns = {b5, b4, b3, b2, b1};

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        btn_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb (
            .clk   (clk),
            .rst   (rst),
            .tick  (tick),
            .btn   (btns[g]),
            .press (press[g])
        );
    end

    logic [NUM_BTN-1:0] pending_q, pending_d, grant;
    btn_id_t            mem [FIFO_DEPTH];
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               valid_q, valid_d;
    btn_id_t            id_q, id_d, push_id;
    logic               overflow_d;
    logic               full, push, pop;

    // Lowest pending index wins; outputs are precomputed from next FIFO state so they stay registered.
    always_comb begin
        grant   = '0;
        push_id = '0;
        for (int i = int'(NUM_BTN) - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                grant   = '0;
                grant[i] = 1'b1;
                push_id = btn_id(i);
            end
        end

        full = (cnt_q == CW'(FIFO_DEPTH));
        pop  = valid_q && req.req_ready;
        push = (|pending_q) && (!full || pop);

        pending_d  = (pending_q & ~(push ? grant : '0)) | (press & ~pending_q);
        overflow_d = overflow || (|(press & pending_q));

        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;

        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase

        valid_d = (cnt_d != '0);
        if (!valid_d) begin
            id_d = '0;
        end else if (push && (wr_ptr_q == rd_ptr_d)) begin
            id_d = push_id;
        end else begin
            id_d = mem[rd_ptr_d];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_q <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            id_q      <= '0;
            overflow  <= 1'b0;
        end else begin
            pending_q <= pending_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            id_q      <= id_d;
            overflow  <= overflow_d;
        end
    end

    // Storage needs no reset: validity is tracked entirely by the count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= push_id;
        end
    end

    assign req.req_valid = valid_q;
    assign req.req_id    = id_q;

endmodule

// File: tb/tb_btn_req_gen.sv
// Directed bench for btn_req_gen: press-scenario table plus multi-cycle corner sequences.
module tb_btn_req_gen;
    import lfu_pkg::*;

    logic       clk;
    logic       rst;
    logic       tick;
    logic [4:0] btn;
    logic       ready;
    logic       overflow;

    btn_req_gen_if req_bus ();
    assign req_bus.req_ready = ready;

    btn_req_gen dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .b1       (btn[0]),
        .b2       (btn[1]),
        .b3       (btn[2]),
        .b4       (btn[3]),
        .b5       (btn[4]),
        .req      (req_bus),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Debounce sample strobe: one cycle in four.
    int unsigned tcnt = 0;
    initial begin
        tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tcnt = tcnt + 1;
            tick = (tcnt % 4 == 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [4:0]      mask;
        int              n;
        logic [4:0][2:0] ids;
    } vec_t;

    vec_t vecs [5];

    int checks = 0;
    int errors = 0;
    int idle_bad = 0;
    int cycle = 0;
    int got [$];
    int cyc [$];

    task automatic check(input string name, input integer act, input integer exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: drive buttons, sample at the falling edge, record accepted ids.
    task automatic step(input logic [4:0] b);
        btn = b;
        @(negedge clk);
        if (req_bus.req_valid === 1'b1 && ready === 1'b1) begin
            got.push_back(int'(req_bus.req_id));
            cyc.push_back(cycle);
        end
        if (req_bus.req_valid !== 1'b1 && req_bus.req_id !== 3'd0) idle_bad++;
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic window(input logic [4:0] mask, input int hold, input int total);
        for (int c = 0; c < total; c++) step((c < hold) ? mask : 5'b0);
    endtask

    task automatic clear_log();
        got.delete();
        cyc.delete();
    endtask

    task automatic wait_valid(input string name, input int budget);
        int k;
        k = 0;
        while (req_bus.req_valid !== 1'b1 && k < budget) begin
            step(btn);
            k++;
        end
        check(name, int'(req_bus.req_valid === 1'b1), 1);
    endtask

    initial begin
        vecs[0] = '{mask: 5'b00100, n: 1, ids: {3'd0, 3'd0, 3'd0, 3'd0, 3'd3}};
        vecs[1] = '{mask: 5'b11001, n: 3, ids: {3'd0, 3'd0, 3'd5, 3'd4, 3'd1}};
        vecs[2] = '{mask: 5'b00110, n: 2, ids: {3'd0, 3'd0, 3'd0, 3'd3, 3'd2}};
        vecs[3] = '{mask: 5'b11111, n: 5, ids: {3'd5, 3'd4, 3'd3, 3'd2, 3'd1}};
        vecs[4] = '{mask: 5'b10000, n: 1, ids: {3'd0, 3'd0, 3'd0, 3'd0, 3'd5}};

        rst   = 1'b0;
        btn   = 5'b0;
        ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", req_bus.req_valid, 0);
        check("rst_id", req_bus.req_id, 0);
        check("rst_overflow", overflow, 0);
        rst = 1'b1;
        repeat (4) step(5'b0);

        // Press table with the LFU always ready.
        foreach (vecs[v]) begin
            clear_log();
            window(vecs[v].mask, 24, 64);
            check($sformatf("vec%0d_count", v), got.size(), vecs[v].n);
            for (int i = 0; i < vecs[v].n && i < got.size(); i++)
                check($sformatf("vec%0d_id%0d", v, i), got[i], int'(vecs[v].ids[i]));
            if (got.size() == vecs[v].n && vecs[v].n > 1)
                check($sformatf("vec%0d_consecutive", v), cyc[vecs[v].n-1] - cyc[0], vecs[v].n - 1);
            check($sformatf("vec%0d_overflow", v), overflow, 0);
        end

        // Bounce: b2 toggles once per tick period, then rests low.
        clear_log();
        for (int k = 0; k < 10; k++) begin
            for (int c = 0; c < 4; c++) step((k % 2 == 0) ? 5'b00010 : 5'b00000);
        end
        window(5'b0, 0, 24);
        check("bounce_count", got.size(), 0);
        check("bounce_overflow", overflow, 0);

        // Backpressure: fill the FIFO, leave b5 pending, then re-press b5.
        ready = 1'b0;
        clear_log();
        for (int i = 0; i < 5; i++) window(5'b00001 << i, 20, 44);
        check("bp_valid", req_bus.req_valid, 1);
        check("bp_head", req_bus.req_id, 1);
        check("bp_overflow_before", overflow, 0);
        window(5'b10000, 20, 44);
        check("bp_overflow_after", overflow, 1);
        check("bp_no_pop", got.size(), 0);
        ready = 1'b1;
        window(5'b0, 0, 20);
        check("drain_count", got.size(), 5);
        for (int i = 0; i < 5 && i < got.size(); i++)
            check($sformatf("drain_id%0d", i), got[i], i + 1);

        // Stall: req_id=2 held five cycles, pop on the first ready cycle only.
        ready = 1'b0;
        clear_log();
        window(5'b00010, 20, 8);
        wait_valid("stall_reach_valid", 40);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("stall_valid_c%0d", c), req_bus.req_valid, 1);
            check($sformatf("stall_id_c%0d", c), req_bus.req_id, 2);
            @(posedge clk);
            #1;
        end
        ready = 1'b1;
        @(negedge clk);
        check("stall_pop_valid", req_bus.req_valid, 1);
        check("stall_pop_id", req_bus.req_id, 2);
        @(posedge clk);
        #1;
        check("stall_after_pop", req_bus.req_valid, 0);
        window(5'b0, 0, 40);
        check("stall_no_extra", got.size(), 0);

        // Reset mid-operation with three queued requests and overflow set.
        ready = 1'b0;
        window(5'b00111, 20, 44);
        check("pre_rst_valid", req_bus.req_valid, 1);
        check("pre_rst_overflow", overflow, 1);
        rst = 1'b0;
        #1;
        check("mid_rst_valid", req_bus.req_valid, 0);
        check("mid_rst_id", req_bus.req_id, 0);
        check("mid_rst_overflow", overflow, 0);
        repeat (3) @(posedge clk);
        #1;
        rst   = 1'b1;
        ready = 1'b1;
        clear_log();
        window(5'b0, 0, 40);
        check("post_rst_stale", got.size(), 0);

        // Button held through reset is debounced as a fresh press.
        btn = 5'b00100;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        clear_log();
        window(5'b00100, 24, 64);
        check("held_rst_count", got.size(), 1);
        if (got.size() > 0) check("held_rst_id", got[0], 3);

        check("idle_id_zero", idle_bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
